alu_mul_sequencer: RTL and testbench

- Multi-cycle controller that computes the RISC-V MUL result (low 32 bits of the product) by sequencing the existing shared ALU through iterative shift-add ADD operations.
- Sits beside the EX stage. While running, it owns the ALU operand/control inputs through an ownership flag and stalls the pipeline.
- Low 32 product bits are identical for signed and unsigned operands, so no sign handling is needed.

---
 rtl/alu_mul_sequencer_pkg.sv | 23 ++
 rtl/alu_mul_sequencer.sv | 136 +++++++++++++
 tb/tb_alu_mul_sequencer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_mul_sequencer_pkg.sv
// Shared definitions for the MUL sequencer: ALU control codes, widths and FSM states.
package alu_mul_sequencer_pkg;

  // Default operand width and iteration counter width (log2 of the width)
  localparam int XLEN_DEF  = 32;
  localparam int CNT_W_DEF = 5;

  // ALU control encodings shared with the EX-stage ALU
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NONE = 4'b0000;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Iterative shift-add multiplier (low XLEN product bits) that borrows the shared
// EX-stage ALU for its additions. While running it owns the ALU inputs and
// raises busy so the hazard unit stalls the pipeline.
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [XLEN-1:0] Op1,
  input  logic [XLEN-1:0] Op2,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            alu_own,
  output logic [XLEN-1:0] AluOp1,
  output logic [XLEN-1:0] AluOp2,
  output logic [3:0]      AluCtrl,
  input  logic [XLEN-1:0] AluResult
);

  mul_state_t       state_r, state_d;
  logic [XLEN-1:0]  acc_r;
  logic [XLEN-1:0]  m_r;
  logic [XLEN-1:0]  q_r;
  logic [CNT_W-1:0] cnt_r;
  logic [XLEN-1:0]  result_r;

  logic             load;
  logic             step;
  logic             finish;
  logic             last_iter;
  logic [XLEN-1:0]  acc_next;

  // Accumulator only takes the ALU sum when the current multiplier bit is set;
  // stop once no set bits remain above bit 0 or after the final bit position.
  assign acc_next  = q_r[0] ? AluResult : acc_r;
  assign last_iter = (q_r[XLEN-1:1] == '0) || (cnt_r == CNT_W'(XLEN-1));

  // Next-state and control decode; flush overrides any start or completion
  always_comb begin
    state_d = state_r;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    ready   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    alu_own = 1'b0;
    case (state_r)
      IDLE: begin
        ready = 1'b1;
        if (start && !flush) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        alu_own = 1'b1;
        if (flush) begin
          state_d = IDLE;
        end else begin
          step = 1'b1;
          if (last_iter) begin
            finish  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        ready = 1'b1;
        if (flush) begin
          state_d = IDLE;
        end else begin
          done = 1'b1;
          if (start) begin
            load    = 1'b1;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ALU drive: operands from the datapath while owned, zeros otherwise
  always_comb begin
    AluOp1  = '0;
    AluOp2  = '0;
    AluCtrl = ALU_NONE;
    if (alu_own) begin
      AluOp1  = acc_r;
      AluOp2  = m_r;
      AluCtrl = ALU_ADD;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_d;
  end

  // Datapath registers: operand capture on start, one shift-add step per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r    <= '0;
      m_r      <= '0;
      q_r      <= '0;
      cnt_r    <= '0;
      result_r <= '0;
    end else if (load) begin
      acc_r <= '0;
      m_r   <= Op1;
      q_r   <= Op2;
      cnt_r <= '0;
    end else if (step) begin
      acc_r <= acc_next;
      m_r   <= m_r << 1;
      q_r   <= q_r >> 1;
      cnt_r <= cnt_r + CNT_W'(1);
      if (finish) result_r <= acc_next;
    end
  end

  assign result = result_r;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for the MUL sequencer with a behavioural model of the shared ALU.
module tb_alu_mul_sequencer;
  import alu_mul_sequencer_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        alu_own;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  alu_mul_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .flush     (flush),
    .Op1       (op1),
    .Op2       (op2),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .alu_own   (alu_own),
    .AluOp1    (alu_op1),
    .AluOp2    (alu_op2),
    .AluCtrl   (alu_ctrl),
    .AluResult (alu_result)
  );

  // External shared ALU: only ADD matters here
  assign alu_result = (alu_ctrl == ALU_ADD) ? (alu_op1 + alu_op2) : 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for exactly one edge
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    op1   = a;
    op2   = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called right after the start edge; counts edges until done, busy cycles, and non-ADD busy cycles
  task automatic wait_done(output int edges, output int busy_cyc, output int bad_ctrl);
    edges    = 1;
    busy_cyc = 0;
    bad_ctrl = 0;
    while (!done && edges < 40) begin
      if (busy) begin
        busy_cyc++;
        if (alu_ctrl !== ALU_ADD || alu_own !== 1'b1) bad_ctrl++;
      end
      tick();
      edges++;
    end
  endtask

  int e, b, bc;

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op1   = '0;
    op2   = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_ready",   32'(ready),   32'd1);
    check("rst_done",    32'(done),    32'd0);
    check("rst_own",     32'(alu_own), 32'd0);
    check("rst_result",  result,       32'd0);
    check("rst_aluctrl", 32'(alu_ctrl), 32'd0);
    #7 rst_n = 1'b1;

    // 7 * 6: three RUN cycles, done after the fourth edge
    issue(32'd7, 32'd6);
    check("t1_aluop1", alu_op1, 32'd0);
    check("t1_aluop2", alu_op2, 32'd7);
    check("t1_ready",  32'(ready), 32'd0);
    wait_done(e, b, bc);
    check("t1_edges",  32'(e),  32'd4);
    check("t1_busy",   32'(b),  32'd3);
    check("t1_ctrl",   32'(bc), 32'd0);
    check("t1_result", result,  32'd42);
    check("t1_ready_done", 32'(ready), 32'd1);
    tick();
    check("t1_done_pulse", 32'(done), 32'd0);
    check("t1_idle_op1", alu_op1, 32'd0);
    check("t1_hold", result, 32'd42);

    // -1 * -1: full 32 iterations
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(e, b, bc);
    check("t2_edges",  32'(e), 32'd33);
    check("t2_busy",   32'(b), 32'd32);
    check("t2_result", result, 32'h0000_0001);
    tick();

    // -3 * 7 wraps to -21
    issue(32'hFFFF_FFFD, 32'd7);
    wait_done(e, b, bc);
    check("t2b_edges",  32'(e), 32'd4);
    check("t2b_result", result, 32'hFFFF_FFEB);
    tick();

    // Multiplier of 1: single iteration
    issue(32'hDEAD_BEEF, 32'd1);
    wait_done(e, b, bc);
    check("t2c_edges",  32'(e), 32'd2);
    check("t2c_result", result, 32'hDEAD_BEEF);
    tick();

    // Multiplier of 0, then back-to-back start from DONE
    issue(32'h1234_5678, 32'd0);
    wait_done(e, b, bc);
    check("t3_edges",  32'(e), 32'd2);
    check("t3_result", result, 32'd0);
    check("t3_ready",  32'(ready), 32'd1);
    issue(32'd3, 32'd5);
    check("t3_b2b_busy", 32'(busy), 32'd1);
    wait_done(e, b, bc);
    check("t3_b2b_edges",  32'(e), 32'd4);
    check("t3_b2b_result", result, 32'd15);
    tick();

    // Flush on RUN cycle 10 of a long operation
    issue(32'd9, 32'h8000_0000);
    for (int i = 0; i < 9; i++) tick();
    check("t4_still_busy", 32'(busy), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t4_busy",   32'(busy),    32'd0);
    check("t4_own",    32'(alu_own), 32'd0);
    check("t4_done",   32'(done),    32'd0);
    check("t4_ready",  32'(ready),   32'd1);
    check("t4_result", result,       32'd15);
    bc = 0;
    for (int i = 0; i < 30; i++) begin
      if (done || busy) bc++;
      tick();
    end
    check("t4_no_done", 32'(bc), 32'd0);
    check("t4_hold",    result,  32'd15);

    // Flush in IDLE blocks a simultaneous start
    flush = 1'b1;
    issue(32'd4, 32'd4);
    flush = 1'b0;
    check("t4b_blocked", 32'(busy), 32'd0);

    // Start during RUN is ignored
    issue(32'd2, 32'd3);
    op1   = 32'd100;
    op2   = 32'd100;
    start = 1'b1;
    tick();
    start = 1'b0;
    e = 2;
    while (!done && e < 40) begin
      tick();
      e++;
    end
    check("t5_edges",  32'(e), 32'd3);
    check("t5_result", result, 32'd6);
    tick();
    check("t5_no_restart", 32'(busy), 32'd0);

    // Asynchronous reset between edges mid-RUN
    issue(32'd11, 32'h0000_00FF);
    tick();
    tick();
    #3 rst_n = 1'b0;
    #1;
    check("t6_busy",   32'(busy),    32'd0);
    check("t6_own",    32'(alu_own), 32'd0);
    check("t6_done",   32'(done),    32'd0);
    check("t6_result", result,       32'd0);
    check("t6_aluop2", alu_op2,      32'd0);
    #1 rst_n = 1'b1;
    tick();
    check("t6_idle", 32'(ready), 32'd1);
    issue(32'd5, 32'd5);
    wait_done(e, b, bc);
    check("t6_edges",  32'(e), 32'd4);
    check("t6_result", result, 32'd25);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
